// File: rtl/sos_pkg.sv
// Shared constants, FSM encoding and saturation helper
// for the cascaded biquad engine.
package sos_pkg;

  localparam int SOS_BW   = 9;
  localparam int SOS_CW   = 9;
  localparam int SOS_FRAC = 7;
  localparam int SOS_N    = 4;
  localparam int SOS_SW   = 4;
  localparam int ACC_W    = SOS_BW + SOS_CW + 3;

  localparam logic [2:0] IDX_B0 = 3'd0;
  localparam logic [2:0] IDX_B1 = 3'd1;
  localparam logic [2:0] IDX_B2 = 3'd2;
  localparam logic [2:0] IDX_A1 = 3'd3;
  localparam logic [2:0] IDX_A2 = 3'd4;

  localparam logic signed [ACC_W-1:0] SAT_HI =
    ACC_W'(2 ** (SOS_BW - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    OUT
  } state_e;

  function automatic logic signed [SOS_BW-1:0] sat_bw(
    input logic signed [ACC_W-1:0] v
  );
    if (v > SAT_HI) return SAT_HI[SOS_BW-1:0];
    if (v < SAT_LO) return SAT_LO[SOS_BW-1:0];
    return v[SOS_BW-1:0];
  endfunction

endpackage

// File: rtl/sos_mac.sv
// One Direct-Form-II biquad section: feedback, feedforward,
// floor shift and saturation, fully combinational.
import sos_pkg::*;

module sos_mac #(
  parameter int BW   = SOS_BW,
  parameter int CW   = SOS_CW,
  parameter int FRAC = SOS_FRAC
) (
  input  logic signed [BW-1:0] x,
  input  logic signed [BW-1:0] w1,
  input  logic signed [BW-1:0] w2,
  input  logic signed [CW-1:0] b0,
  input  logic signed [CW-1:0] b1,
  input  logic signed [CW-1:0] b2,
  input  logic signed [CW-1:0] a1,
  input  logic signed [CW-1:0] a2,
  output logic signed [BW-1:0] w,
  output logic signed [BW-1:0] y
);

  localparam int PW = BW + CW;
  localparam int AW = BW + CW + 3;

  logic signed [PW-1:0] p_a1, p_a2;
  logic signed [PW-1:0] p_b0, p_b1, p_b2;
  logic signed [AW-1:0] acc_w, acc_y;
  logic signed [BW-1:0] w_sat;

  always_comb begin
    p_a1  = a1 * w1;
    p_a2  = a2 * w2;
    // x is an integer sample; align it to the Q(FRAC) products
    acc_w = (AW'(x) <<< FRAC)
          - AW'(p_a1) - AW'(p_a2);
    w_sat = sat_bw(acc_w >>> FRAC);
    p_b0  = b0 * w_sat;
    p_b1  = b1 * w1;
    p_b2  = b2 * w2;
    acc_y = AW'(p_b0) + AW'(p_b1) + AW'(p_b2);
    y     = sat_bw(acc_y >>> FRAC);
  end

  assign w = w_sat;

endmodule

// File: rtl/sos_cascade_engine.sv
// Time-multiplexed biquad cascade: one shared MAC walks
// every section, one per clock, for each accepted sample.
import sos_pkg::*;

module sos_cascade_engine #(
  parameter int BW      = SOS_BW,
  parameter int No_SOS  = SOS_N,
  parameter int CW      = SOS_CW,
  parameter int FRAC    = SOS_FRAC,
  parameter int STAGE_W = SOS_SW
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   clear,
  input  logic signed [BW-1:0]   in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic signed [BW-1:0]   out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   coef_we,
  input  logic [STAGE_W+2:0]     coef_addr,
  input  logic signed [CW-1:0]   coef_wdata
);

  localparam logic [STAGE_W-1:0] LAST =
    STAGE_W'(No_SOS - 1);
  localparam logic signed [CW-1:0] ONE =
    CW'(1 << FRAC);

  typedef logic signed [BW-1:0] smp_t;
  typedef logic signed [CW-1:0] cf_t;

  state_e             state_q, state_d;
  logic [STAGE_W-1:0] sec_q, sec_d;
  smp_t               x_q, x_d;
  smp_t               out_q, out_d;
  smp_t               w1_q [No_SOS];
  smp_t               w1_d [No_SOS];
  smp_t               w2_q [No_SOS];
  smp_t               w2_d [No_SOS];
  cf_t                coef_q [No_SOS][5];
  cf_t                coef_d [No_SOS][5];

  logic [STAGE_W-1:0] csec;
  logic [2:0]         cidx;
  logic               coef_hit;
  smp_t               mac_w, mac_y;

  assign csec     = coef_addr[STAGE_W+2:3];
  assign cidx     = coef_addr[2:0];
  assign coef_hit = coef_we && (cidx <= IDX_A2)
                 && (csec <= LAST);

  sos_mac #(
    .BW   (BW),
    .CW   (CW),
    .FRAC (FRAC)
  ) u_mac (
    .x  (x_q),
    .w1 (w1_q[sec_q]),
    .w2 (w2_q[sec_q]),
    .b0 (coef_q[sec_q][IDX_B0]),
    .b1 (coef_q[sec_q][IDX_B1]),
    .b2 (coef_q[sec_q][IDX_B2]),
    .a1 (coef_q[sec_q][IDX_A1]),
    .a2 (coef_q[sec_q][IDX_A2]),
    .w  (mac_w),
    .y  (mac_y)
  );

  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    x_d     = x_q;
    out_d   = out_q;
    w1_d    = w1_q;
    w2_d    = w2_q;
    coef_d  = coef_q;
    if (coef_hit) coef_d[csec][cidx] = coef_wdata;
    if (clear) begin
      for (int s = 0; s < No_SOS; s++) begin
        w1_d[s] = '0;
        w2_d[s] = '0;
      end
      state_d = IDLE;
      sec_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_d     = in_data;
            sec_d   = '0;
            state_d = CALC;
          end
        end
        CALC: begin
          w2_d[sec_q] = w1_q[sec_q];
          w1_d[sec_q] = mac_w;
          x_d         = mac_y;
          if (sec_q == LAST) begin
            out_d   = mac_y;
            state_d = OUT;
          end else begin
            sec_d = sec_q + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      sec_q   <= '0;
      x_q     <= '0;
      out_q   <= '0;
      for (int s = 0; s < No_SOS; s++) begin
        w1_q[s] <= '0;
        w2_q[s] <= '0;
        for (int i = 0; i < 5; i++) begin
          coef_q[s][i] <= (i == 0) ? ONE : '0;
        end
      end
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      x_q     <= x_d;
      out_q   <= out_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      coef_q  <= coef_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !clear;
  assign out_valid = (state_q == OUT);
  assign out_data  = out_q;

endmodule
